// File: rtl/lbist_misr_compactor.sv
// ----------------------------------------------------------------------------
// lbist_misr_compactor
//
// LBIST response compactor. It folds the scan-out bits of every scan chain
// into a multiple-input signature register (MISR) on each shift cycle. It
// counts shifts per pattern and patterns per run. At the end of the run it
// compares the final signature against a golden value and drives the
// go/no-go verdict.
//
// Optional feature (compile-time macro LBIST_MISR_MASK_EN):
//   When defined, the block gains input chain_mask_i. A chain whose mask bit
//   is set contributes 0 to the MISR, so unconnected or X-producing scan-outs
//   can be excluded. When undefined, all chains are compacted unmasked.
//
// Ports
//   clk_i                in   clock
//   rst_ni               in   asynchronous active-low reset
//   start_i              in   begin a run (sampled in IDLE/DONE only)
//   shift_en_i           in   scan shift active; compact this cycle's inputs
//   scan_chain_output_i  in   [NUM_CHAINS] scan-out bits, bit k = chain k+1
//   chain_mask_i         in   [NUM_CHAINS] per-chain mask (LBIST_MISR_MASK_EN)
//   busy_o               out  run in progress (COMPACT or COMPARE)
//   done_o               out  run complete, held until next start
//   go_nogo_o            out  1 = final signature matched GOLDEN_SIG
//   signature_o          out  [MISR_WIDTH] current MISR contents
//   pattern_cnt_o        out  [$clog2(NUM_PATTERNS+1)] completed patterns
// ----------------------------------------------------------------------------
module lbist_misr_compactor #(
   parameter int unsigned            NUM_CHAINS   = 20,
   parameter int unsigned            MISR_WIDTH   = 32,
   parameter logic [MISR_WIDTH-1:0]  MISR_POLY    = 32'h04C11DB7,
   parameter logic [MISR_WIDTH-1:0]  MISR_SEED    = '0,
   parameter int unsigned            CHAIN_LEN    = 64,
   parameter int unsigned            NUM_PATTERNS = 1024,
   parameter logic [MISR_WIDTH-1:0]  GOLDEN_SIG   = '0
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  start_i,
   input  logic                                  shift_en_i,
   input  logic [NUM_CHAINS-1:0]                 scan_chain_output_i,
`ifdef LBIST_MISR_MASK_EN
   input  logic [NUM_CHAINS-1:0]                 chain_mask_i,
`endif
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic                                  go_nogo_o,
   output logic [MISR_WIDTH-1:0]                 signature_o,
   output logic [$clog2(NUM_PATTERNS+1)-1:0]     pattern_cnt_o
);

   localparam int unsigned PCW = $clog2(NUM_PATTERNS + 1);
   localparam int unsigned SCW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPACT,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t                r_state;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_go_nogo;
   logic [MISR_WIDTH-1:0] r_sig;
   logic [PCW-1:0]        r_pat_cnt;
   logic [SCW-1:0]        r_shift_cnt;

   logic [NUM_CHAINS-1:0] w_chain_data;
   logic [MISR_WIDTH-1:0] w_misr_in;
   logic [MISR_WIDTH-1:0] w_misr_next;
   logic                  w_last_shift;
   logic                  w_last_pattern;

`ifdef LBIST_MISR_MASK_EN
   assign w_chain_data = scan_chain_output_i & ~chain_mask_i;
`else
   assign w_chain_data = scan_chain_output_i;
`endif

   // Zero-extend the chain bits onto the low end of the MISR.
   always_comb begin
      w_misr_in                 = '0;
      w_misr_in[NUM_CHAINS-1:0] = w_chain_data;
   end

   assign w_misr_next = {r_sig[MISR_WIDTH-2:0], 1'b0}
                      ^ (r_sig[MISR_WIDTH-1] ? MISR_POLY : '0)
                      ^ w_misr_in;

   assign w_last_shift   = (r_shift_cnt == SCW'(CHAIN_LEN - 1));
   assign w_last_pattern = (r_pat_cnt == PCW'(NUM_PATTERNS - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_go_nogo   <= 1'b0;
         r_sig       <= MISR_SEED;
         r_pat_cnt   <= '0;
         r_shift_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  r_state     <= S_COMPACT;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_go_nogo   <= 1'b0;
                  r_sig       <= MISR_SEED;
                  r_pat_cnt   <= '0;
                  r_shift_cnt <= '0;
               end
            end
            S_COMPACT: begin
               if (shift_en_i) begin
                  r_sig <= w_misr_next;
                  if (w_last_shift) begin
                     r_shift_cnt <= '0;
                     r_pat_cnt   <= r_pat_cnt + PCW'(1);
                     // Final pattern: leave COMPACT on the same edge so the
                     // counters can never run past NUM_PATTERNS.
                     if (w_last_pattern) begin
                        r_state <= S_COMPARE;
                     end
                  end else begin
                     r_shift_cnt <= r_shift_cnt + SCW'(1);
                  end
               end
            end
            S_COMPARE: begin
               r_go_nogo <= (r_sig == GOLDEN_SIG);
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_o        = r_busy;
   assign done_o        = r_done;
   assign go_nogo_o     = r_go_nogo;
   assign signature_o   = r_sig;
   assign pattern_cnt_o = r_pat_cnt;

endmodule

// File: tb/tb_lbist_misr_compactor.sv
// ----------------------------------------------------------------------------
// tb_lbist_misr_compactor
//
// Three instances share one stimulus stream:
//   0: SEED=00, GOLDEN=08
//   1: SEED=00, GOLDEN=09
//   2: SEED=80, GOLDEN=1D
// A behavioural model tracks the run per instance. The model uses
// polynomial-division arithmetic on integers. Both the model and the known
// constant values are compared against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_lbist_misr_compactor;

   localparam int NI = 3;
   localparam int CL = 2;
   localparam int NP = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       shen = 1'b0;
   logic [3:0] scan = '0;
   logic [3:0] mask = '0;

   logic       busy_o [NI];
   logic       done_o [NI];
   logic       go_o   [NI];
   logic [7:0] sig_o  [NI];
   logic [1:0] pat_o  [NI];

   localparam logic [7:0] SEEDS [NI] = '{8'h00, 8'h00, 8'h80};
   localparam logic [7:0] GOLDS [NI] = '{8'h08, 8'h09, 8'h1D};

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   logic [7:0] m_sig [NI];
   logic       m_go  [NI];
   logic       m_busy, m_done, m_cmp;
   int         m_shift, m_pat;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      lbist_misr_compactor #(
         .NUM_CHAINS   (4),
         .MISR_WIDTH   (8),
         .MISR_POLY    (8'h1D),
         .MISR_SEED    (SEEDS[g]),
         .CHAIN_LEN    (CL),
         .NUM_PATTERNS (NP),
         .GOLDEN_SIG   (GOLDS[g])
      ) u_dut (
         .clk_i               (clk),
         .rst_ni              (rst_n),
         .start_i             (start),
         .shift_en_i          (shen),
         .scan_chain_output_i (scan),
`ifdef LBIST_MISR_MASK_EN
         .chain_mask_i        (mask),
`endif
         .busy_o              (busy_o[g]),
         .done_o              (done_o[g]),
         .go_nogo_o           (go_o[g]),
         .signature_o         (sig_o[g]),
         .pattern_cnt_o       (pat_o[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Signature step as polynomial arithmetic: multiply by x modulo
   // x^8 + poly, then add the input word.
   function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [3:0] d);
      int t;
      t = int'(s) * 2;
      if (t >= 256) t = (t - 256) ^ 'h1D;
      return 8'(t) ^ {4'h0, d};
   endfunction

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_cmp = 0; m_shift = 0; m_pat = 0;
      for (int i = 0; i < NI; i++) begin
         m_sig[i] = SEEDS[i];
         m_go[i]  = 0;
      end
   endtask

   task automatic model_edge(input logic st, input logic sh, input logic [3:0] d);
      logic [3:0] de;
`ifdef LBIST_MISR_MASK_EN
      de = d & ~mask;
`else
      de = d;
`endif
      if (m_cmp) begin
         m_cmp = 0; m_busy = 0; m_done = 1;
         for (int i = 0; i < NI; i++) m_go[i] = (m_sig[i] == GOLDS[i]);
      end else if (m_busy) begin
         if (sh) begin
            for (int i = 0; i < NI; i++) m_sig[i] = misr_ref(m_sig[i], de);
            m_shift++;
            if (m_shift == CL) begin
               m_shift = 0;
               m_pat++;
               if (m_pat == NP) m_cmp = 1;
            end
         end
      end else if (st) begin
         m_busy = 1; m_done = 0; m_shift = 0; m_pat = 0;
         for (int i = 0; i < NI; i++) begin
            m_sig[i] = SEEDS[i];
            m_go[i]  = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s.sig%0d", tag, i), 32'(sig_o[i]), 32'(m_sig[i]));
         chk($sformatf("%s.pat%0d", tag, i), 32'(pat_o[i]), 32'(m_pat));
         chk($sformatf("%s.busy%0d", tag, i), 32'(busy_o[i]), 32'(m_busy));
         chk($sformatf("%s.done%0d", tag, i), 32'(done_o[i]), 32'(m_done));
         chk($sformatf("%s.go%0d", tag, i), 32'(go_o[i]), 32'(m_go[i]));
      end
   endtask

   // Drive one cycle, then sample 1 time unit after the rising edge.
   task automatic step(input string tag, input logic st, input logic sh, input logic [3:0] d);
      start = st; shen = sh; scan = d;
      @(posedge clk);
      model_edge(st, sh, d);
      #1;
      check_all(tag);
      start = 0; shen = 0; scan = '0;
   endtask

   task automatic check_reset_vals(input string tag);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s.busy%0d", tag, i), 32'(busy_o[i]), 0);
         chk($sformatf("%s.done%0d", tag, i), 32'(done_o[i]), 0);
         chk($sformatf("%s.go%0d", tag, i), 32'(go_o[i]), 0);
         chk($sformatf("%s.sig%0d", tag, i), 32'(sig_o[i]), 32'(SEEDS[i]));
         chk($sformatf("%s.pat%0d", tag, i), 32'(pat_o[i]), 0);
      end
   endtask

   initial begin
      logic [3:0] run_d [4];
      logic [7:0] fresh_sig;
      logic [7:0] sv;
      int         cyc;

      model_reset();
      // ---- reset
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      rst_n = 1;
      @(posedge clk); #1;
      check_reset_vals("rst_rel");

      // ---- impulse response
      step("imp_start", 1, 0, 4'h0);
      step("imp1", 0, 1, 4'h1); chk("imp_sig1", 32'(sig_o[0]), 32'h01);
      step("imp2", 0, 1, 4'h0); chk("imp_sig2", 32'(sig_o[0]), 32'h02);
      step("imp3", 0, 1, 4'h0); chk("imp_sig3", 32'(sig_o[0]), 32'h04);
      step("imp4", 0, 1, 4'h0); chk("imp_sig4", 32'(sig_o[0]), 32'h08);
      chk("imp_done_early", 32'(done_o[0]), 0);
      chk("imp_pat", 32'(pat_o[0]), 2);
      // COMPARE occupies one cycle; shifts offered here must be ignored.
      step("imp_cmp", 0, 1, 4'hF);
      chk("imp_done", 32'(done_o[0]), 1);
      chk("imp_go08", 32'(go_o[0]), 1);
      chk("imp_go09", 32'(go_o[1]), 0);
      chk("imp_sig_frozen", 32'(sig_o[0]), 32'h08);

      // ---- signature frozen in DONE
      sv = sig_o[0];
      step("done_hold", 0, 1, 4'hA);
      chk("done_hold_sig", 32'(sig_o[0]), 32'(sv));

      // ---- feedback + stall + mid-run start
      step("fb_start", 1, 0, 4'h0);
      chk("fb_done_clr", 32'(done_o[0]), 0);
      step("fb1", 0, 1, 4'h0);
      chk("fb_sig", 32'(sig_o[2]), 32'h1D);
      sv = sig_o[0];
      step("stall1", 0, 0, 4'h7);
      step("stall2", 1, 0, 4'h5);
      chk("stall_sig", 32'(sig_o[0]), 32'(sv));
      chk("stall_pat", 32'(pat_o[0]), 0);
      step("stall_shift2", 0, 1, 4'h3);
      chk("stall_pat1", 32'(pat_o[0]), 1);
      step("mid_start", 1, 1, 4'h6);
      step("fin", 0, 1, 4'h9);
      step("fin_cmp", 0, 0, 4'h0);
      chk("fin_done", 32'(done_o[0]), 1);

      // ---- randomized runs
      for (int r = 0; r < 20; r++) begin
         step("rnd_start", 1, 0, 4'($urandom));
         cyc = 0;
         while (!m_done && cyc < 200) begin
            step("rnd", 1'($urandom_range(0, 7) == 0), 1'($urandom), 4'($urandom));
            cyc++;
         end
         if (cyc >= 200) chk("rnd_timeout", 1, 0);
         step("rnd_idle", 0, 1'($urandom), 4'($urandom));
      end

      // ---- reset mid-run, then rerun the same data
      for (int k = 0; k < 4; k++) run_d[k] = 4'($urandom);
      step("ref_start", 1, 0, 4'h0);
      for (int k = 0; k < 4; k++) step("ref", 0, 1, run_d[k]);
      step("ref_cmp", 0, 0, 4'h0);
      fresh_sig = m_sig[0];
      step("ab_start", 1, 0, 4'h0);
      for (int k = 0; k < 3; k++) step("ab", 0, 1, run_d[k]);
      rst_n = 0;
      #1;
      model_reset();
      check_reset_vals("ab_rst");
      @(posedge clk); #1;
      check_reset_vals("ab_rst_hold");
      rst_n = 1;
      step("re_start", 1, 0, 4'h0);
      for (int k = 0; k < 4; k++) step("re", 0, 1, run_d[k]);
      step("re_cmp", 0, 0, 4'h0);
      chk("re_same_sig", 32'(sig_o[0]), 32'(fresh_sig));
      chk("re_done", 32'(done_o[0]), 1);

`ifdef LBIST_MISR_MASK_EN
      // ---- mask removes chain 0 entirely
      mask = 4'h1;
      step("mk_start", 1, 0, 4'h0);
      step("mk1", 0, 1, 4'h1);
      step("mk2", 0, 1, 4'h0);
      step("mk3", 0, 1, 4'h0);
      step("mk4", 0, 1, 4'h0);
      chk("mk_sig", 32'(sig_o[0]), 32'h00);
      mask = 4'h0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
